// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate/opclass enums and the
// decoded bundle carried from decode_fields into the stage register.
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_kind_e;

  typedef enum logic [3:0] {
    OC_OP, OC_OP_IMM, OC_LOAD, OC_STORE, OC_BRANCH, OC_JAL, OC_JALR,
    OC_LUI, OC_AUIPC, OC_MISC_MEM, OC_SYSTEM, OC_MULDIV
  } opclass_e;

  // Immediate is kept outside the struct so its width can follow DATA_WIDTH.
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    imm_kind_e  imm_kind;
    logic [2:0] funct3;
    logic       alt;
    opclass_e   opclass;
    logic       illegal;
  } bundle_t;

endpackage

// File: rtl/decode_fields.sv
// Purely combinational RV32I(M) field decode: instruction word to bundle
// plus sign-extended immediate.
module decode_fields
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit ENABLE_M   = 1'b0
) (
  input  logic [31:0]           instr,
  output bundle_t               bundle,
  output logic [DATA_WIDTH-1:0] imm
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        use_rd, use_rs1, use_rs2, illegal, alt;
  imm_kind_e   kind;
  opclass_e    opclass;
  logic [31:0] imm32;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    illegal = 1'b0;
    alt     = 1'b0;
    kind    = IMM_NONE;
    opclass = OC_OP;
    case (opcode)
      OPC_OP: begin
        {use_rd, use_rs1, use_rs2} = 3'b111;
        alt = instr[30];
        if (funct7 == FUNCT7_MULDIV) begin
          if (ENABLE_M) opclass = OC_MULDIV;
          else          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        {use_rd, use_rs1} = 2'b11;
        kind    = IMM_I;
        opclass = OC_OP_IMM;
        // instr[30] only selects SRAI vs SRLI; elsewhere it is immediate data
        alt     = instr[30] && (funct3 == 3'b001 || funct3 == 3'b101);
      end
      OPC_LOAD: begin
        {use_rd, use_rs1} = 2'b11;
        kind    = IMM_I;
        opclass = OC_LOAD;
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        {use_rs1, use_rs2} = 2'b11;
        kind    = IMM_S;
        opclass = OC_STORE;
        illegal = funct3 > 3'd2;
      end
      OPC_BRANCH: begin
        {use_rs1, use_rs2} = 2'b11;
        kind    = IMM_B;
        opclass = OC_BRANCH;
        illegal = funct3[2:1] == 2'b01;
      end
      OPC_JAL:    begin use_rd = 1'b1; kind = IMM_J; opclass = OC_JAL; end
      OPC_JALR: begin
        {use_rd, use_rs1} = 2'b11;
        kind    = IMM_I;
        opclass = OC_JALR;
        illegal = funct3 != 3'b000;
      end
      OPC_LUI:    begin use_rd = 1'b1; kind = IMM_U; opclass = OC_LUI;   end
      OPC_AUIPC:  begin use_rd = 1'b1; kind = IMM_U; opclass = OC_AUIPC; end
      OPC_MISC_MEM: begin {use_rd, use_rs1} = 2'b11; kind = IMM_I; opclass = OC_MISC_MEM; end
      OPC_SYSTEM:   begin {use_rd, use_rs1} = 2'b11; kind = IMM_I; opclass = OC_SYSTEM;   end
      default:    illegal = 1'b1;
    endcase
    if (illegal) begin
      {use_rd, use_rs1, use_rs2, alt} = 4'b0000;
      kind    = IMM_NONE;
      opclass = OC_OP;
    end
  end

  always_comb begin
    case (kind)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    imm        = {DATA_WIDTH{imm32[31]}};
    imm[31:0]  = imm32;
  end

  always_comb begin
    bundle          = '0;
    bundle.rd       = use_rd  ? instr[11:7]  : 5'd0;
    bundle.rs1      = use_rs1 ? instr[19:15] : 5'd0;
    bundle.rs2      = use_rs2 ? instr[24:20] : 5'd0;
    bundle.imm_kind = kind;
    bundle.funct3   = funct3;
    bundle.alt      = alt;
    bundle.opclass  = opclass;
    bundle.illegal  = illegal;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decode_fields followed by a single valid/ready
// output register with flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int ENABLE_M   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [DATA_WIDTH-1:0] out_imm,
  output imm_kind_e             out_imm_kind,
  output logic [2:0]            out_funct3,
  output logic                  out_alt,
  output opclass_e              out_opclass,
  output logic                  out_illegal
);

  bundle_t               dec, bundle_q;
  logic [DATA_WIDTH-1:0] dec_imm, imm_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic                  valid_q, accept;

  decode_fields #(
    .DATA_WIDTH (DATA_WIDTH),
    .ENABLE_M   (ENABLE_M != 0)
  ) u_fields (
    .instr  (in_instr),
    .bundle (dec),
    .imm    (dec_imm)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Flush wins over an accept in the same cycle; data only moves on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      bundle_q <= '0;
      imm_q    <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      pc_q     <= in_pc;
      bundle_q <= dec;
      imm_q    <= dec_imm;
    end else if (out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_rd       = bundle_q.rd;
  assign out_rs1      = bundle_q.rs1;
  assign out_rs2      = bundle_q.rs2;
  assign out_imm      = imm_q;
  assign out_imm_kind = bundle_q.imm_kind;
  assign out_funct3   = bundle_q.funct3;
  assign out_alt      = bundle_q.alt;
  assign out_opclass  = bundle_q.opclass;
  assign out_illegal  = bundle_q.illegal;

endmodule
